// File: rtl/ccip_arb_pkg.sv
// Shared types and defaults for the CCI-P c1 write arbiter.
// The request struct is sized by the default widths; the arbiter instantiates with those widths.
package ccip_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int ADDR_W_DEF  = 42;
  localparam int DATA_W_DEF  = 512;
  localparam int MDATA_W_DEF = 16;
  localparam int OUTST_W     = 10;

  // Number of upper mdata bits that carry the requester index.
  function automatic int tag_w(input int n_req);
    return $clog2(n_req);
  endfunction

  typedef logic [OUTST_W-1:0] t_arb_outst;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  addr;
    logic [DATA_W_DEF-1:0]  data;
    logic [MDATA_W_DEF-1:0] mdata;
  } t_arb_wr_req;

endpackage

// File: rtl/ccip_c1_write_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: combinational one-hot grant, search starts one past the last winner.
// Latency 0 (grant is combinational); pointer moves only when advance is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 pClk,
  input  logic                 pReset_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] last_q, last_d;
  logic             found;
  int               idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && found) last_d = gnt_idx;
  end

  // Reset to the last index so requester 0 has top priority first.
  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) last_q <= IDX_W'(N - 1);
    else           last_q <= last_d;
  end

endmodule

// File: rtl/ccip_c1_write_arbiter.sv
// Round-robin sharing of the CCI-P c1 write channel; 1-cycle request->c1_tx and response->rsp latency.
// Backpressure: no grant while registered c1_almfull is high or a requester hits MAX_OUTST; ARB_STATS_EN adds counters.
module ccip_c1_write_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MDATA_W   = MDATA_W_DEF,
  parameter int MAX_OUTST = 64,
  localparam int TAG_W    = tag_w(N_REQ),
  localparam int PRIV_W   = MDATA_W - TAG_W
) (
  input  logic                           pClk,
  input  logic                           pReset_n,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0][PRIV_W-1:0]   req_mdata,
  output logic [N_REQ-1:0]               req_ready,
  input  logic                           c1_almfull,
  output logic                           c1_tx_valid,
  output logic [ADDR_W-1:0]              c1_tx_addr,
  output logic [DATA_W-1:0]              c1_tx_data,
  output logic [MDATA_W-1:0]             c1_tx_mdata,
  input  logic                           c1_rx_rsp_valid,
  input  logic [MDATA_W-1:0]             c1_rx_rsp_mdata,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [PRIV_W-1:0]              rsp_mdata,
  output logic [N_REQ-1:0][31:0]         stat_grants,
  output logic [31:0]                    stat_stall
);

  logic                         almfull_q;
  logic                         tx_vld_q, tx_vld_d;
  t_arb_wr_req                  tx_q, tx_d;
  logic [N_REQ-1:0]             rsp_vld_q, rsp_hit;
  logic [PRIV_W-1:0]            rsp_mdata_q, rsp_mdata_d;
  t_arb_outst [N_REQ-1:0]       outst_q, outst_d;
  logic [N_REQ-1:0]             elig, gnt;
  logic [TAG_W-1:0]             gnt_idx;
  logic [TAG_W-1:0]             rsp_tag;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (outst_q[i] < t_arb_outst'(MAX_OUTST)) && !almfull_q;
    end
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .pClk     (pClk),
    .pReset_n (pReset_n),
    .req      (elig),
    .advance  (|gnt),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign req_ready = gnt;

  always_comb begin
    tx_d     = tx_q;
    tx_vld_d = |gnt;
    if (|gnt) begin
      tx_d.addr  = req_addr[gnt_idx];
      tx_d.data  = req_data[gnt_idx];
      tx_d.mdata = {gnt_idx, req_mdata[gnt_idx]};
    end
  end

  assign rsp_tag = c1_rx_rsp_mdata[MDATA_W-1 -: TAG_W];

  // Tags beyond N_REQ belong to nobody and are dropped.
  always_comb begin
    rsp_hit     = '0;
    rsp_mdata_d = rsp_mdata_q;
    if (c1_rx_rsp_valid && (int'(rsp_tag) < N_REQ)) begin
      rsp_hit[rsp_tag] = 1'b1;
      rsp_mdata_d      = c1_rx_rsp_mdata[PRIV_W-1:0];
    end
  end

  // A response against a zero count (e.g. issued before a reset) is forwarded but not counted.
  always_comb begin
    outst_d = outst_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i] && !(rsp_hit[i] && outst_q[i] != '0)) begin
        outst_d[i] = outst_q[i] + t_arb_outst'(1);
      end else if (!gnt[i] && rsp_hit[i] && outst_q[i] != '0) begin
        outst_d[i] = outst_q[i] - t_arb_outst'(1);
      end
    end
  end

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      almfull_q   <= 1'b1;
      tx_vld_q    <= 1'b0;
      tx_q        <= '0;
      rsp_vld_q   <= '0;
      rsp_mdata_q <= '0;
      outst_q     <= '0;
    end else begin
      almfull_q   <= c1_almfull;
      tx_vld_q    <= tx_vld_d;
      tx_q        <= tx_d;
      rsp_vld_q   <= rsp_hit;
      rsp_mdata_q <= rsp_mdata_d;
      outst_q     <= outst_d;
    end
  end

  assign c1_tx_valid = tx_vld_q;
  assign c1_tx_addr  = tx_q.addr;
  assign c1_tx_data  = tx_q.data;
  assign c1_tx_mdata = tx_q.mdata;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_mdata   = rsp_mdata_q;

`ifdef ARB_STATS_EN
  logic [N_REQ-1:0][31:0] stat_grants_q, stat_grants_d;
  logic [31:0]            stat_stall_q, stat_stall_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stat_grants_d[i] = stat_grants_q[i] + 32'(gnt[i]);
    end
    stat_stall_d = stat_stall_q + 32'((|req_valid) && !(|gnt));
  end

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_grants = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_ccip_c1_write_arbiter.sv
// Scoreboarded bench for ccip_c1_write_arbiter (MAX_OUTST=2); stat checks follow ARB_STATS_EN.
`timescale 1ns/1ps
module tb_ccip_c1_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int MW = 16;
  localparam int TW = 2;
  localparam int LW = MW - TW;

  logic                 pClk = 1'b0;
  logic                 pReset_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0][LW-1:0] req_mdata;
  logic [N-1:0]         req_ready;
  logic                 c1_almfull;
  logic                 c1_tx_valid;
  logic [AW-1:0]        c1_tx_addr;
  logic [DW-1:0]        c1_tx_data;
  logic [MW-1:0]        c1_tx_mdata;
  logic                 c1_rx_rsp_valid;
  logic [MW-1:0]        c1_rx_rsp_mdata;
  logic [N-1:0]         rsp_valid;
  logic [LW-1:0]        rsp_mdata;
  logic [N-1:0][31:0]   stat_grants;
  logic [31:0]          stat_stall;

  ccip_c1_write_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MDATA_W(MW), .MAX_OUTST(2)
  ) dut (
    .pClk(pClk), .pReset_n(pReset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_mdata(req_mdata),
    .req_ready(req_ready), .c1_almfull(c1_almfull),
    .c1_tx_valid(c1_tx_valid), .c1_tx_addr(c1_tx_addr), .c1_tx_data(c1_tx_data), .c1_tx_mdata(c1_tx_mdata),
    .c1_rx_rsp_valid(c1_rx_rsp_valid), .c1_rx_rsp_mdata(c1_rx_rsp_mdata),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata),
    .stat_grants(stat_grants), .stat_stall(stat_stall)
  );

  always #5 pClk = ~pClk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [MW-1:0] mdata; int due; } wr_exp_t;
  typedef struct { logic [N-1:0] vld; logic [LW-1:0] mdata; int due; } rsp_exp_t;

  wr_exp_t  wr_q[$];
  rsp_exp_t rsp_q[$];
  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  int       seq[N];
  bit       auto_rsp = 1'b0;

  always @(posedge pClk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] f_addr(input int i, input int s);
    return AW'(i * 65536 + s * 3 + 256);
  endfunction

  function automatic logic [DW-1:0] f_data(input int i, input int s);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = 32'(i * 1000003 + s * 7 + k);
    return d;
  endfunction

  function automatic logic [LW-1:0] f_mdata(input int i, input int s);
    return LW'(i * 256 + s + 3);
  endfunction

  task automatic apply_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = f_addr(i, seq[i]);
      req_data[i]  = f_data(i, seq[i]);
      req_mdata[i] = f_mdata(i, seq[i]);
    end
  endtask

  // One clock of stimulus: samples req_ready mid-cycle, records the write expected next cycle.
  task automatic drive_cycle(input logic [N-1:0] exp_gnt, output logic [N-1:0] got);
    wr_exp_t e;
    @(negedge pClk);
    got = req_ready;
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) begin
        e.addr  = f_addr(i, seq[i]);
        e.data  = f_data(i, seq[i]);
        e.mdata = {TW'(i), f_mdata(i, seq[i])};
        e.due   = cyc + 1;
        wr_q.push_back(e);
      end
    end
    @(posedge pClk);
    #1;
    for (int i = 0; i < N; i++) if (got[i] && req_valid[i]) seq[i]++;
    apply_payload();
  endtask

  task automatic do_reset();
    pReset_n        = 1'b0;
    req_valid       = '0;
    c1_almfull      = 1'b0;
    auto_rsp        = 1'b0;
    c1_rx_rsp_valid = 1'b0;
    c1_rx_rsp_mdata = '0;
    repeat (2) @(posedge pClk);
    #1;
    pReset_n = 1'b1;
  endtask

  task automatic mon_wr();
    wr_exp_t  e;
    rsp_exp_t r;
    forever begin
      @(negedge pClk);
      if (pReset_n === 1'b1) begin
        if (auto_rsp) c1_rx_rsp_valid = 1'b0;
        if (c1_tx_valid !== 1'b0) begin
          total++;
          if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected: got valid=%b mdata=%h at cyc %0d, required no write", c1_tx_valid, c1_tx_mdata, cyc);
          end else begin
            e = wr_q.pop_front();
            if (c1_tx_addr !== e.addr || c1_tx_data !== e.data || c1_tx_mdata !== e.mdata || cyc != e.due) begin
              bad++;
              $display("FAIL wr_out: got addr=%h mdata=%h data_ok=%0d cyc=%0d, required addr=%h mdata=%h cyc=%0d",
                       c1_tx_addr, c1_tx_mdata, c1_tx_data === e.data, cyc, e.addr, e.mdata, e.due);
            end
            if (auto_rsp) begin
              c1_rx_rsp_valid = 1'b1;
              c1_rx_rsp_mdata = e.mdata;
              r.vld   = 4'b0001 << e.mdata[MW-1 -: TW];
              r.mdata = e.mdata[LW-1:0];
              r.due   = cyc + 1;
              rsp_q.push_back(r);
            end
          end
        end
      end
    end
  endtask

  task automatic mon_rsp();
    rsp_exp_t r;
    forever begin
      @(negedge pClk);
      if (pReset_n === 1'b1 && rsp_valid !== '0) begin
        total++;
        if (rsp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b mdata=%h at cyc %0d, required none", rsp_valid, rsp_mdata, cyc);
        end else begin
          r = rsp_q.pop_front();
          if (rsp_valid !== r.vld || rsp_mdata !== r.mdata || cyc != r.due) begin
            bad++;
            $display("FAIL rsp_out: got vld=%b mdata=%h cyc=%0d, required vld=%b mdata=%h cyc=%0d",
                     rsp_valid, rsp_mdata, cyc, r.vld, r.mdata, r.due);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    #2;
    pReset_n  = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(negedge pClk);
    total += 6;
    if (req_ready !== '0)   begin bad++; $display("FAIL rst_ready: got %b required 0", req_ready); end
    if (c1_tx_valid !== 0)  begin bad++; $display("FAIL rst_tx_valid: got %b required 0", c1_tx_valid); end
    if (rsp_valid !== '0)   begin bad++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    if (c1_tx_mdata !== '0 || c1_tx_addr !== '0) begin bad++; $display("FAIL rst_fields: got addr=%h mdata=%h required 0", c1_tx_addr, c1_tx_mdata); end
    if (stat_stall !== '0)  begin bad++; $display("FAIL rst_stall: got %0d required 0", stat_stall); end
    if (stat_grants !== '0) begin bad++; $display("FAIL rst_grants: got %h required 0", stat_grants); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_t [6];
    logic [N-1:0] got;
    exp_t = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    auto_rsp  = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(exp_t[k], got);
      total++;
      if (got !== exp_t[k]) begin bad++; $display("FAIL rr_grant c%0d: got %b required %b", k, got, exp_t[k]); end
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle('0, got);
      total++;
      if (got !== '0) begin bad++; $display("FAIL rr_idle c%0d: got %b required 0", k, got); end
    end
  endtask

  task automatic test_almfull();
    logic [N-1:0] exp_t [11];
    logic [N-1:0] got;
    exp_t = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001,
              4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};
    do_reset();
    auto_rsp  = 1'b1;
    req_valid = 4'b0101;
    for (int k = 0; k < 11; k++) begin
      c1_almfull = (k >= 5 && k <= 7);
      drive_cycle(exp_t[k], got);
      total++;
      if (got !== exp_t[k]) begin bad++; $display("FAIL almfull_grant c%0d: got %b required %b", k, got, exp_t[k]); end
    end
    req_valid  = '0;
    c1_almfull = 1'b0;
    repeat (4) drive_cycle('0, got);
  endtask

  task automatic test_outstanding();
    logic [N-1:0] exp_t [7];
    logic [N-1:0] got;
    rsp_exp_t     r;
    exp_t = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    do_reset();
    req_valid = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        c1_rx_rsp_valid = 1'b1;
        c1_rx_rsp_mdata = 16'h4123;
        r.vld = 4'b0010; r.mdata = 14'h0123; r.due = cyc + 1;
        rsp_q.push_back(r);
      end else begin
        c1_rx_rsp_valid = 1'b0;
      end
      drive_cycle(exp_t[k], got);
      total++;
      if (got !== exp_t[k]) begin bad++; $display("FAIL outst_grant c%0d: got %b required %b", k, got, exp_t[k]); end
    end
    req_valid = '0;
    repeat (3) drive_cycle('0, got);
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp_t [5];
    logic [N-1:0] got;
    rsp_exp_t     r;
    exp_t = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    do_reset();
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        c1_rx_rsp_valid = 1'b1;
        c1_rx_rsp_mdata = 16'hAABC;
        r.vld = 4'b0100; r.mdata = 14'h2ABC; r.due = cyc + 1;
        rsp_q.push_back(r);
      end else begin
        c1_rx_rsp_valid = 1'b0;
      end
      drive_cycle(exp_t[k], got);
      total++;
      if (got !== exp_t[k]) begin bad++; $display("FAIL simul_grant c%0d: got %b required %b", k, got, exp_t[k]); end
    end
    req_valid = '0;
    repeat (3) drive_cycle('0, got);
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] got;
    rsp_exp_t     r;
    do_reset();
    auto_rsp  = 1'b1;
    req_valid = 4'b1111;
    drive_cycle(4'b0000, got);
    drive_cycle(4'b0001, got);
    drive_cycle(4'b0010, got);
    total++;
    if (c1_tx_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: got tx_valid=%b required 1", c1_tx_valid); end
    pReset_n = 1'b0;
    #1;
    total += 4;
    if (c1_tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_tx: got %b required 0", c1_tx_valid); end
    if (rsp_valid !== '0)     begin bad++; $display("FAIL midrst_rsp: got %b required 0", rsp_valid); end
    if (req_ready !== '0)     begin bad++; $display("FAIL midrst_ready: got %b required 0", req_ready); end
    if (c1_tx_addr !== '0 || c1_tx_mdata !== '0 || rsp_mdata !== '0) begin
      bad++; $display("FAIL midrst_fields: got addr=%h mdata=%h rsp_mdata=%h required 0", c1_tx_addr, c1_tx_mdata, rsp_mdata);
    end
    auto_rsp        = 1'b0;
    c1_rx_rsp_valid = 1'b0;
    wr_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge pClk);
    #1;
    pReset_n = 1'b1;
    drive_cycle(4'b0000, got);
    total++;
    if (got !== 4'b0000) begin bad++; $display("FAIL midrst_c0: got %b required 0000", got); end
    drive_cycle(4'b0001, got);
    total++;
    if (got !== 4'b0001) begin bad++; $display("FAIL midrst_first: got %b required 0001", got); end
    req_valid = '0;
    // Late response for a write issued before the reset: still forwarded.
    c1_rx_rsp_valid = 1'b1;
    c1_rx_rsp_mdata = 16'h4055;
    r.vld = 4'b0010; r.mdata = 14'h0055; r.due = cyc + 1;
    rsp_q.push_back(r);
    drive_cycle('0, got);
    c1_rx_rsp_valid = 1'b0;
    repeat (3) drive_cycle('0, got);
  endtask

  task automatic test_stats();
    logic [N-1:0]       exp_t [10];
    logic [N-1:0]       got;
    logic [N-1:0][31:0] exp_g;
    logic [31:0]        exp_s;
    exp_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
              4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
`ifdef ARB_STATS_EN
    exp_g = {32'd1, 32'd2, 32'd2, 32'd2};
    exp_s = 32'd3;
`else
    exp_g = '0;
    exp_s = '0;
`endif
    do_reset();
    auto_rsp = 1'b1;
    drive_cycle('0, got);
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      c1_almfull = (k >= 3 && k <= 5);
      drive_cycle(exp_t[k], got);
      total++;
      if (got !== exp_t[k]) begin bad++; $display("FAIL stats_grant c%0d: got %b required %b", k, got, exp_t[k]); end
    end
    req_valid  = '0;
    c1_almfull = 1'b0;
    @(negedge pClk);
    for (int i = 0; i < N; i++) begin
      total++;
      if (stat_grants[i] !== exp_g[i]) begin bad++; $display("FAIL stat_grants[%0d]: got %0d required %0d", i, stat_grants[i], exp_g[i]); end
    end
    total++;
    if (stat_stall !== exp_s) begin bad++; $display("FAIL stat_stall: got %0d required %0d", stat_stall, exp_s); end
    repeat (4) drive_cycle('0, got);
  endtask

  initial begin
    pReset_n        = 1'b1;
    req_valid       = '0;
    c1_almfull      = 1'b0;
    c1_rx_rsp_valid = 1'b0;
    c1_rx_rsp_mdata = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    apply_payload();
    fork
      mon_wr();
      mon_rsp();
    join_none
    test_reset();
    test_round_robin();
    test_almfull();
    test_outstanding();
    test_simultaneous();
    test_mid_reset();
    test_stats();
    total += 2;
    if (wr_q.size() != 0)  begin bad++; $display("FAIL wr_missing: got %0d writes still pending, required 0", wr_q.size()); end
    if (rsp_q.size() != 0) begin bad++; $display("FAIL rsp_missing: got %0d responses still pending, required 0", rsp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccip_c1_write_arbiter.md
# ccip_c1_write_arbiter

Round-robin arbiter that shares the CCI-P c1 (write request) Tx channel among N_REQ internal write requesters and routes c1 write responses back to the issuing requester. Sits between the NIC datapath engines and the CCI-P port, in the same clock domain as the top-level networking module. Enforces c1TxAlmFull backpressure and a per-requester outstanding-write limit.

## Interface
- N_REQ, 4: number of requesters, 2..8
- ADDR_W, 42: CCI-P line address width
- DATA_W, 512: cache-line data width
- MDATA_W, 16: CCI-P mdata width; the upper TAG_W = $clog2(N_REQ) bits are owned by the arbiter
- MAX_OUTST, 64: maximum outstanding writes per requester, 1..1023
- pClk  in  1  block clock; all logic is in this single domain
- pReset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester write request
- req_addr  in  N_REQ×ADDR_W  line address
- req_data  in  N_REQ×DATA_W  line data
- req_mdata  in  N_REQ×(MDATA_W−TAG_W)  requester-private tag
- req_ready  out  N_REQ  one-hot grant; the request is consumed in the cycle it is high
- c1_almfull  in  1  CCI-P c1TxAlmFull
- c1_tx_valid  out  1  registered c1 write request valid
- c1_tx_addr / c1_tx_data / c1_tx_mdata  out  ADDR_W / DATA_W / MDATA_W  registered request fields
- c1_rx_rsp_valid  in  1  c1 write response (WrLine response type only)
- c1_rx_rsp_mdata  in  MDATA_W  response mdata
- rsp_valid  out  N_REQ  one-hot response pulse
- rsp_mdata  out  MDATA_W−TAG_W  requester tag echoed back
- stat_grants  out  N_REQ×32  grant counters (see Configuration)
- stat_stall  out  32  stall-cycle counter (see Configuration)

## Operation
- Requester i is eligible when req_valid[i] is high, outst[i] < MAX_OUTST, and almfull_q is 0.
- almfull_q is c1_almfull registered once. The one-cycle lag is covered by the CCI-P 8-entry almost-full slack.
- Round-robin: the search starts at last_grant+1 and wraps modulo N_REQ. At most one req_ready is asserted per cycle, combinationally from the eligibility terms. last_grant updates only on a grant.
- On a grant, the output register loads addr, data, and mdata = {i[TAG_W−1:0], req_mdata[i]}, and c1_tx_valid is set to 1. With no grant, c1_tx_valid is 0 the next cycle.
- A response with mdata upper TAG_W = j gives rsp_valid[j] = 1 and rsp_mdata = low bits, registered. Out-of-range j (≥ N_REQ) is dropped.
- outst[i] is 10 bits: +1 on grant, −1 on response. Simultaneous grant and response for the same i leaves it unchanged. It never underflows: a response when outst = 0 is dropped from the counter but still forwarded.
- Reset (async assert, any time): c1_tx_valid = 0, rsp_valid = 0, req_ready = 0, all fields = 0, outst = 0, last_grant = N_REQ−1 (so requester 0 wins first), almfull_q = 1, stats = 0.
- Reset deasserted mid-transfer: in-flight writes are forgotten, and their later responses are forwarded but not counted.

## Timing
- Request-to-c1_tx latency is 1 cycle (grant at cycle t, c1_tx_valid at t+1).
- Response latency is 1 cycle.
- Back-to-back grants are possible every cycle, sustaining 1 line/cycle.
- c1_almfull rising at t blocks grants from t+1. Falling at t allows grants from t+1.
- req_* inputs must be held stable while req_valid is high and req_ready is low.

## Configuration
- ARB_STATS_EN defined:
  - stat_grants[i] increments on each grant to i.
  - stat_stall increments each cycle in which some req_valid is high but no grant is made.
  - All counters wrap at 2^32.
- ARB_STATS_EN undefined: the stat ports are driven constant 0 and no counter logic is built.

## Structure
- Package ccip_arb_pkg holds:
  - the N_REQ default and the TAG_W function
  - typedef t_arb_wr_req {addr, data, mdata}
  - typedef t_arb_outst (10-bit)
- Sub-module rr_arbiter: parameter N, inputs pClk, pReset_n, req[N], advance; outputs gnt[N] one-hot and gnt_idx. It contains the rotating-priority pointer.

## Test plan
- Reset release with req_valid = 4'b1111 and no almfull → grants in order 0,1,2,3,0. c1_tx_mdata upper 2 bits follow, one line per cycle.
- req_valid = 4'b0101 with almfull asserted at cycle 5 → at most one grant at cycle 5, none while almfull = 1, and resumes at the next index after almfull falls.
- MAX_OUTST = 2, requester 1 alone, no responses → two grants then req_ready[1] = 0. One response with mdata = 0x4xxx (tag 1) → outst 2→1 and one further grant.
- Grant and response for requester 2 in the same cycle with outst = 1 → outst stays 1, and rsp_valid = 4'b0100 one cycle later with the echoed tag.
- pReset_n asserted during a burst → all outputs 0 immediately. After release, requester 0 is granted first.
- ARB_STATS_EN, 10 cycles of all-valid with almfull for 3 of them → stat_grants sums to 7 (±1 for the almfull register lag) and stat_stall = 3 (±1).
